// File: rtl/value_to_pwm.sv
// value_to_pwm: turns an 8-bit command value into a servo/ESC PWM frame stream
// on the 1 MHz us_clk. The high time of each frame is fixed when that frame starts.
// A value change therefore only takes effect at the next frame boundary.
module value_to_pwm #(
  parameter int unsigned MIN_PWM_TIME_HIGH_US = 1000,
  parameter int unsigned MAX_PWM_TIME_HIGH_US = 2000,
  parameter int unsigned PERIOD_US            = 20000,
  parameter int unsigned PWM_TIME_BIT_WIDTH   = 16
) (
  input  logic                          us_clk,
  input  logic                          resetn,
  input  logic [7:0]                    value_in,
  input  logic                          value_valid,
  input  logic                          enable,
  output logic                          pwm_out,
  output logic                          frame_start,
  output logic [PWM_TIME_BIT_WIDTH-1:0] active_high_us
);

  localparam int unsigned W = PWM_TIME_BIT_WIDTH;
  localparam logic [W-1:0] MIN_W    = W'(MIN_PWM_TIME_HIGH_US);
  localparam logic [W-1:0] MAX_W    = W'(MAX_PWM_TIME_HIGH_US);
  localparam logic [W-1:0] PERIOD_W = W'(PERIOD_US);
  localparam logic [W-1:0] ONE_W    = W'(1);
  localparam logic [W-1:0] ZERO_W   = W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // High time for a command value: MIN + 4*value, saturated at MAX.
  function automatic logic [W-1:0] calc_high_time(input logic [7:0] v);
    logic [W-1:0] t;
    t = MIN_W + W'({v, 2'b00});
    if (t > MAX_W) begin
      return MAX_W;
    end else begin
      return t;
    end
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] counter_q, counter_d;
  logic [W-1:0] active_q, active_d;
  logic [7:0]   shadow_q, shadow_d;
  logic         pwm_q, pwm_d;
  logic         frame_start_q, frame_start_d;

  // Next-state logic: shadow capture, frame latch and the IDLE/HIGH/LOW sequencing.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    active_d      = active_q;
    pwm_d         = pwm_q;
    frame_start_d = 1'b0;

    // The frame latch below reads shadow_q, so a write on the latch edge
    // lands one frame later.
    if (value_valid) begin
      shadow_d = value_in;
    end else begin
      shadow_d = shadow_q;
    end

    case (state_q)
      ST_IDLE: begin
        pwm_d     = 1'b0;
        counter_d = ZERO_W;
        if (enable) begin
          active_d      = calc_high_time(shadow_q);
          counter_d     = ONE_W;
          pwm_d         = 1'b1;
          frame_start_d = 1'b1;
          state_d       = ST_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        counter_d = counter_q + ONE_W;
        if (counter_q == active_q) begin
          pwm_d   = 1'b0;
          state_d = ST_LOW;
        end else begin
          pwm_d   = 1'b1;
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (counter_q == PERIOD_W) begin
          if (enable) begin
            // Back-to-back frame: no idle gap between periods.
            active_d      = calc_high_time(shadow_q);
            counter_d     = ONE_W;
            pwm_d         = 1'b1;
            frame_start_d = 1'b1;
            state_d       = ST_HIGH;
          end else begin
            counter_d = ZERO_W;
            pwm_d     = 1'b0;
            state_d   = ST_IDLE;
          end
        end else begin
          counter_d = counter_q + ONE_W;
          pwm_d     = 1'b0;
          state_d   = ST_LOW;
        end
      end
      default: begin
        counter_d = ZERO_W;
        pwm_d     = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the output low immediately.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      counter_q     <= ZERO_W;
      active_q      <= MIN_W;
      shadow_q      <= 8'd0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign frame_start    = frame_start_q;
  assign active_high_us = active_q;

endmodule

// File: tb/tb_value_to_pwm.sv
// Bench for value_to_pwm: the driver pushes the expected high time of each frame
// into a scoreboard queue; a negedge monitor measures every frame the DUT emits
// and compares it against the queue head.
module tb_value_to_pwm;

  localparam int MIN_HI = 1000;
  localparam int MAX_HI = 2000;
  localparam int PERIOD = 2100;  // shortened frame keeps the run short

  typedef struct {
    int hi;
    bit b2b;
  } exp_t;

  logic        us_clk;
  logic        resetn;
  logic [7:0]  value_in;
  logic        value_valid;
  logic        enable;
  logic        pwm_out;
  logic        frame_start;
  logic [15:0] active_high_us;

  int   n_total;
  int   n_bad;
  int   cyc;
  exp_t sb[$];

  int   last_fs;
  bit   have_last;
  bit   in_high;
  int   high_cnt;
  int   cur_hi;

  value_to_pwm #(
    .MIN_PWM_TIME_HIGH_US(MIN_HI),
    .MAX_PWM_TIME_HIGH_US(MAX_HI),
    .PERIOD_US           (PERIOD),
    .PWM_TIME_BIT_WIDTH  (16)
  ) dut (
    .us_clk        (us_clk),
    .resetn        (resetn),
    .value_in      (value_in),
    .value_valid   (value_valid),
    .enable        (enable),
    .pwm_out       (pwm_out),
    .frame_start   (frame_start),
    .active_high_us(active_high_us)
  );

  initial us_clk = 1'b0;
  always #5 us_clk = ~us_clk;

  always @(posedge us_clk) cyc = cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int hi_of(input int v);
    int t;
    t = MIN_HI + 4 * v;
    return (t > MAX_HI) ? MAX_HI : t;
  endfunction

  task automatic push_exp(input int hi, input bit b2b);
    exp_t e;
    e.hi  = hi;
    e.b2b = b2b;
    sb.push_back(e);
  endtask

  task automatic write_value(input int v);
    value_in    = v[7:0];
    value_valid = 1'b1;
    @(posedge us_clk);
    #1;
    value_valid = 1'b0;
  endtask

  // Advance at least one edge, then wait (bounded) for the next frame_start.
  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(posedge us_clk);
      #1;
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("fs_timeout", int'(frame_start), 1);
  endtask

  // Frame monitor: checks every frame against the scoreboard and pwm low otherwise.
  always @(negedge us_clk) begin
    exp_t e;
    if (!resetn) begin
      in_high   = 1'b0;
      have_last = 1'b0;
      check_val("rst_pwm", int'(pwm_out), 0);
      check_val("rst_fs", int'(frame_start), 0);
      check_val("rst_act", int'(active_high_us), MIN_HI);
    end else begin
      if (frame_start) begin
        check_val("fs_pwm", int'(pwm_out), 1);
        if (sb.size() == 0) begin
          check_val("unexp_frame", int'(frame_start), 0);
        end else begin
          e      = sb.pop_front();
          cur_hi = e.hi;
          check_val("act_hi", int'(active_high_us), e.hi);
          if (have_last) begin
            if (e.b2b) check_val("period", cyc - last_fs, PERIOD);
            else       check_val("gap", int'((cyc - last_fs) >= PERIOD), 1);
          end
        end
        have_last = 1'b1;
        last_fs   = cyc;
        in_high   = 1'b1;
        high_cnt  = 0;
      end
      if (in_high) begin
        if (pwm_out) begin
          high_cnt = high_cnt + 1;
          check_val("act_stable", int'(active_high_us), cur_hi);
        end else begin
          check_val("high_time", high_cnt, cur_hi);
          in_high = 1'b0;
        end
      end else begin
        check_val("pwm_low", int'(pwm_out), 0);
      end
    end
  end

  initial begin
    n_total = 0; n_bad = 0; cyc = 0;
    have_last = 1'b0; in_high = 1'b0; high_cnt = 0; cur_hi = 0; last_fs = 0;
    resetn = 1'b0; value_in = 8'd0; value_valid = 1'b0; enable = 1'b0;
    repeat (3) @(posedge us_clk);
    #1;
    resetn = 1'b1;
    repeat (5) @(posedge us_clk);
    #1;
    check_val("idle_pwm0", int'(pwm_out), 0);
    check_val("idle_act0", int'(active_high_us), MIN_HI);

    // Value 0 from reset, then 128 written mid-frame.
    push_exp(hi_of(0), 1'b0);
    enable = 1'b1;
    wait_fs();
    repeat (300) @(posedge us_clk);
    #1;
    write_value(128);
    push_exp(hi_of(128), 1'b1);
    wait_fs();

    // Clamp: 250 and 255 both give MAX.
    write_value(250);
    push_exp(MAX_HI, 1'b1);
    wait_fs();
    write_value(255);
    push_exp(MAX_HI, 1'b1);
    wait_fs();

    // value_valid on the exact latch edge: that frame keeps the old value.
    push_exp(MAX_HI, 1'b1);
    repeat (PERIOD - 1) @(posedge us_clk);
    #1;
    value_in    = 8'd10;
    value_valid = 1'b1;
    @(posedge us_clk);
    #1;
    value_valid = 1'b0;
    check_val("sync_fs", int'(frame_start), 1);
    push_exp(hi_of(10), 1'b1);
    wait_fs();

    // Enable drop at cycle 500: frame completes, then no more frames.
    repeat (499) @(posedge us_clk);
    #1;
    enable = 1'b0;
    repeat (3 * PERIOD) @(posedge us_clk);
    #1;
    check_val("off_pwm", int'(pwm_out), 0);

    // Restart from IDLE has one-cycle latency.
    push_exp(hi_of(10), 1'b0);
    enable = 1'b1;
    @(posedge us_clk);
    #1;
    check_val("idle_lat", int'(frame_start), 1);
    // Drop, then re-assert during LOW: continues back-to-back.
    repeat (499) @(posedge us_clk);
    #1;
    enable = 1'b0;
    repeat (1000) @(posedge us_clk);
    #1;
    enable = 1'b1;
    push_exp(hi_of(10), 1'b1);
    wait_fs();

    // Asynchronous reset during HIGH.
    repeat (200) @(posedge us_clk);
    #3;
    resetn = 1'b0;
    #1;
    check_val("rst_async", int'(pwm_out), 0);
    repeat (3) @(posedge us_clk);
    #1;
    push_exp(MIN_HI, 1'b0);
    resetn = 1'b1;
    wait_fs();
    repeat (100) @(posedge us_clk);
    #1;
    enable = 1'b0;
    repeat (PERIOD + 200) @(posedge us_clk);
    #1;
    check_val("sb_empty", sb.size(), 0);
    check_val("end_pwm", int'(pwm_out), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
